// File: rtl/fu_seq_x.sv
// fu_seq_x: sequential MSP430X ALU, byte/word/address width, 1..16 repeats.
// Ports: MCLK/RST_n; in_valid/in_ready accept op,sz,src,dst,rpt_cnt,rpt_zc,
//   Z/V/N/Cin; flush cancels EXEC; done pulses with result,res_wr,Z/V/N/Cout,err.
// Macro FU_ILLEGAL_TRAP_EN: op=F or sz=11 trap with err=1 and result 0xDEAD.
module fu_seq_x #(
   parameter int DATA_W = 20,
   parameter int RPT_W  = 4
) (
   input  logic              MCLK,
   input  logic              RST_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [1:0]        sz,
   input  logic [DATA_W-1:0] src,
   input  logic [DATA_W-1:0] dst,
   input  logic [RPT_W-1:0]  rpt_cnt,
   input  logic              rpt_zc,
   input  logic              Zin,
   input  logic              Vin,
   input  logic              Nin,
   input  logic              Cin,
   input  logic              flush,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              res_wr,
   output logic              Zout,
   output logic              Vout,
   output logic              Nout,
   output logic              Cout,
   output logic              err
);
   localparam logic [3:0] OP_MOV  = 4'h0, OP_ADD  = 4'h1, OP_ADDC = 4'h2,
                          OP_SUBC = 4'h3, OP_SUB  = 4'h4, OP_CMP  = 4'h5,
                          OP_DADD = 4'h6, OP_BIT  = 4'h7, OP_BIC  = 4'h8,
                          OP_BIS  = 4'h9, OP_XOR  = 4'hA, OP_AND  = 4'hB,
                          OP_RRC  = 4'hC, OP_RRA  = 4'hD, OP_RLA  = 4'hE,
                          OP_RSV  = 4'hF;
`ifdef FU_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif
   localparam logic [DATA_W-1:0] DEAD = DATA_W'(16'hDEAD);

   typedef enum logic {IDLE, EXEC} state_t;
   state_t state_q, state_d;

   logic [3:0]        op_q;
   logic [1:0]        sz_q;
   logic [DATA_W-1:0] src_q, acc_q;
   logic [RPT_W-1:0]  rem_q;
   logic              zc_q, ill_q;
   logic              z_q, v_q, n_q, c_q;

   function automatic logic [DATA_W-1:0] wmask(input logic [1:0] s);
      case (s)
         2'b01:   return DATA_W'(8'hFF);
         2'b10:   return '1;
         default: return DATA_W'(16'hFFFF);
      endcase
   endfunction

   // Illegal encodings fold onto MOV/word; the trap path bypasses the ALU.
   logic              ill_in;
   logic [3:0]        op_in;
   logic [1:0]        sz_in;
   logic [DATA_W-1:0] mask_in;
   assign ill_in  = TRAP_EN && ((op == OP_RSV) || (sz == 2'b11));
   assign op_in   = (op == OP_RSV) ? OP_MOV : op;
   assign sz_in   = (sz == 2'b11) ? 2'b00 : sz;
   assign mask_in = wmask(sz_in);

   assign in_ready = (state_q == IDLE);

   always_ff @(posedge MCLK or negedge RST_n) begin
      if (!RST_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = EXEC;
         EXEC: if (flush || ill_q || rem_q == '0) state_d = IDLE;
      endcase
   end

   logic [DATA_W-1:0] mask, msbm, opb, res, dres;
   logic [DATA_W:0]   cmask, sum;
   logic [4:0]        d;
   logic              cin, ci, sub, dc, upd, nz, nn, nc, nv;

   always_comb begin
      mask  = wmask(sz_q);
      msbm  = mask ^ (mask >> 1);
      cmask = {1'b0, mask} + {{DATA_W{1'b0}}, 1'b1};
      cin   = c_q & ~zc_q;
      sub   = (op_q == OP_SUB) || (op_q == OP_SUBC) || (op_q == OP_CMP);
      opb   = sub ? (~src_q & mask) : src_q;
      case (op_q)
         OP_ADDC, OP_SUBC: ci = cin;
         OP_SUB, OP_CMP:   ci = 1'b1;
         default:          ci = 1'b0;
      endcase
      sum = {1'b0, acc_q} + {1'b0, opb} + {{DATA_W{1'b0}}, ci};
      // BCD chain stops at the top active nibble; higher nibbles stay 0.
      dres = '0;
      dc   = cin;
      d    = '0;
      for (int i = 0; i < DATA_W / 4; i++) begin
         if (mask[4*i]) begin
            d = {1'b0, acc_q[4*i +: 4]} + {1'b0, src_q[4*i +: 4]}
              + {4'b0, dc};
            dc = (d > 5'd9);
            if (dc) d = d - 5'd10;
            dres[4*i +: 4] = d[3:0];
         end
      end
      res = acc_q;
      upd = 1'b1;
      nc  = c_q;
      nv  = v_q;
      unique case (op_q)
         OP_MOV, OP_RSV: begin res = src_q; upd = 1'b0; end
         OP_BIC: begin res = acc_q & ~src_q; upd = 1'b0; end
         OP_BIS: begin res = acc_q | src_q; upd = 1'b0; end
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
            res = sum[DATA_W-1:0] & mask;
            nc  = |(sum & cmask);
            nv  = ((|(acc_q & msbm)) == (|(opb & msbm)))
               && ((|(res & msbm)) != (|(acc_q & msbm)));
         end
         OP_DADD: begin res = dres; nc = dc; nv = 1'b0; end
         OP_AND, OP_BIT: begin
            res = acc_q & src_q;
            nc  = |res;
            nv  = 1'b0;
         end
         OP_XOR: begin
            res = acc_q ^ src_q;
            nc  = |res;
            nv  = (|(src_q & msbm)) & (|(acc_q & msbm));
         end
         OP_RRC: begin
            res = (acc_q >> 1) | (cin ? msbm : '0);
            nc  = acc_q[0];
            nv  = 1'b0;
         end
         OP_RRA: begin
            res = (acc_q >> 1) | (acc_q & msbm);
            nc  = acc_q[0];
            nv  = 1'b0;
         end
         OP_RLA: begin
            res = (acc_q << 1) & mask;
            nc  = |(acc_q & msbm);
            nv  = (|(acc_q & msbm)) ^ (|(res & msbm));
         end
      endcase
      nz = upd ? ~|res : z_q;
      nn = upd ? |(res & msbm) : n_q;
   end

   always_ff @(posedge MCLK or negedge RST_n) begin
      if (!RST_n) begin
         op_q <= '0; sz_q <= '0; src_q <= '0; acc_q <= '0;
         rem_q <= '0; zc_q <= 1'b0; ill_q <= 1'b0;
         z_q <= 1'b0; v_q <= 1'b0; n_q <= 1'b0; c_q <= 1'b0;
         done <= 1'b0; result <= '0; res_wr <= 1'b0; err <= 1'b0;
         Zout <= 1'b0; Vout <= 1'b0; Nout <= 1'b0; Cout <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state_q == IDLE) begin
            if (in_valid) begin
               op_q  <= op_in;
               sz_q  <= sz_in;
               src_q <= src & mask_in;
               acc_q <= dst & mask_in;
               rem_q <= rpt_cnt;
               zc_q  <= rpt_zc;
               ill_q <= ill_in;
               z_q <= Zin; v_q <= Vin; n_q <= Nin; c_q <= Cin;
            end
         end else if (!flush) begin
            if (ill_q) begin
               done   <= 1'b1;
               err    <= 1'b1;
               result <= DEAD;
               res_wr <= 1'b0;
            end else begin
               acc_q <= res;
               z_q <= nz; v_q <= nv; n_q <= nn; c_q <= nc;
               if (rem_q == '0) begin
                  done   <= 1'b1;
                  err    <= 1'b0;
                  result <= res;
                  res_wr <= (op_q != OP_CMP) && (op_q != OP_BIT);
                  Zout <= nz; Vout <= nv; Nout <= nn; Cout <= nc;
               end else begin
                  rem_q <= rem_q - {{(RPT_W-1){1'b0}}, 1'b1};
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_fu_seq_x.sv
// tb_fu_seq_x: directed bench for fu_seq_x at DATA_W=20, RPT_W=4.
// Scenario tasks run in sequence; expected values are hand-computed.
module tb_fu_seq_x;
   logic        MCLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [1:0]  sz = '0;
   logic [19:0] src = '0;
   logic [19:0] dst = '0;
   logic [3:0]  rpt_cnt = '0;
   logic        rpt_zc = 1'b0;
   logic        Zin = 1'b0, Vin = 1'b0, Nin = 1'b0, Cin = 1'b0;
   logic        flush = 1'b0;
   logic        done;
   logic [19:0] result;
   logic        res_wr;
   logic        Zout, Vout, Nout, Cout;
   logic        err;

   int checks = 0;
   int errors = 0;
   int lat;

   fu_seq_x #(.DATA_W(20), .RPT_W(4)) dut (
      .MCLK(MCLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .sz(sz), .src(src), .dst(dst), .rpt_cnt(rpt_cnt),
      .rpt_zc(rpt_zc), .Zin(Zin), .Vin(Vin), .Nin(Nin), .Cin(Cin),
      .flush(flush), .done(done), .result(result), .res_wr(res_wr),
      .Zout(Zout), .Vout(Vout), .Nout(Nout), .Cout(Cout), .err(err)
   );

   always #5 MCLK = ~MCLK;

   task automatic drive(input bit now, input logic [3:0] o,
                        input logic [1:0] s, input logic [19:0] sv,
                        input logic [19:0] dv, input logic [3:0] r,
                        input logic zc, input logic [3:0] f);
      if (!now) @(negedge MCLK);
      in_valid = 1'b1; op = o; sz = s; src = sv; dst = dv;
      rpt_cnt = r; rpt_zc = zc;
      {Zin, Vin, Nin, Cin} = f;
      @(negedge MCLK);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int l);
      l = 1;
      while (done !== 1'b1 && l < 40) begin
         @(negedge MCLK);
         l++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge MCLK);
      checks++;
      if (in_ready !== 1'b1) begin errors++;
         $display("FAIL reset in_ready got %b exp 1", in_ready); end
      checks++;
      if (done !== 1'b0) begin errors++;
         $display("FAIL reset done got %b exp 0", done); end
      checks++;
      if (result !== 20'h0) begin errors++;
         $display("FAIL reset result got %h exp 00000", result); end
      checks++;
      if ({res_wr, Zout, Vout, Nout, Cout, err} !== 6'b0) begin errors++;
         $display("FAIL reset wr_flags_err got %b exp 000000",
                  {res_wr, Zout, Vout, Nout, Cout, err}); end
      RST_n = 1'b1;
   endtask

   task automatic test_add_word();
      drive(0, 4'h1, 2'b00, 20'h07FFF, 20'h00001, 4'd0, 0, 4'b0000);
      checks++;
      if (in_ready !== 1'b0) begin errors++;
         $display("FAIL add_w busy in_ready got %b exp 0", in_ready); end
      wait_done(lat);
      checks++;
      if (lat !== 2) begin errors++;
         $display("FAIL add_w latency got %0d exp 2", lat); end
      checks++;
      if (result !== 20'h08000) begin errors++;
         $display("FAIL add_w result got %h exp 08000", result); end
      checks++;
      if ({Zout, Vout, Nout, Cout, res_wr, err} !== 6'b011010) begin errors++;
         $display("FAIL add_w zvnc_wr_err got %b exp 011010",
                  {Zout, Vout, Nout, Cout, res_wr, err}); end
      @(negedge MCLK);
      checks++;
      if (done !== 1'b0 || result !== 20'h08000) begin errors++;
         $display("FAIL add_w pulse_hold got done=%b res=%h exp 0 08000",
                  done, result); end
   endtask

   task automatic test_rrc_addr();
      drive(0, 4'hC, 2'b10, 20'h00000, 20'h00001, 4'd3, 0, 4'b0001);
      wait_done(lat);
      checks++;
      if (lat !== 5) begin errors++;
         $display("FAIL rrc latency got %0d exp 5", lat); end
      checks++;
      if (result !== 20'h30000) begin errors++;
         $display("FAIL rrc result got %h exp 30000", result); end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b0000) begin errors++;
         $display("FAIL rrc zvnc got %b exp 0000",
                  {Zout, Vout, Nout, Cout}); end
      drive(0, 4'hC, 2'b10, 20'h00000, 20'h00001, 4'd3, 1, 4'b0001);
      wait_done(lat);
      checks++;
      if (lat !== 5 || result !== 20'h00000) begin errors++;
         $display("FAIL rrc_zc lat_res got %0d %h exp 5 00000", lat, result);
      end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b1000) begin errors++;
         $display("FAIL rrc_zc zvnc got %b exp 1000",
                  {Zout, Vout, Nout, Cout}); end
   endtask

   task automatic test_width_dadd();
      drive(0, 4'h1, 2'b01, 20'h00001, 20'h012FF, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (result !== 20'h00000) begin errors++;
         $display("FAIL add_b result got %h exp 00000", result); end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b1001) begin errors++;
         $display("FAIL add_b zvnc got %b exp 1001",
                  {Zout, Vout, Nout, Cout}); end
      drive(0, 4'h6, 2'b00, 20'h00001, 20'h00999, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (result !== 20'h01000) begin errors++;
         $display("FAIL dadd result got %h exp 01000", result); end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b0000) begin errors++;
         $display("FAIL dadd zvnc got %b exp 0000",
                  {Zout, Vout, Nout, Cout}); end
   endtask

   task automatic test_cmp_misc();
      drive(0, 4'h5, 2'b00, 20'h00005, 20'h00003, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (result !== 20'h0FFFE || res_wr !== 1'b0) begin errors++;
         $display("FAIL cmp res_wr got %h %b exp 0FFFE 0", result, res_wr);
      end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b0010) begin errors++;
         $display("FAIL cmp zvnc got %b exp 0010",
                  {Zout, Vout, Nout, Cout}); end
      drive(0, 4'h0, 2'b00, 20'h01234, 20'h0FFFF, 4'd0, 0, 4'b1011);
      wait_done(lat);
      checks++;
      if (result !== 20'h01234 || res_wr !== 1'b1) begin errors++;
         $display("FAIL mov res_wr got %h %b exp 01234 1", result, res_wr);
      end
      checks++;
      if ({Zout, Vout, Nout, Cout} !== 4'b1011) begin errors++;
         $display("FAIL mov zvnc got %b exp 1011",
                  {Zout, Vout, Nout, Cout}); end
      drive(0, 4'hA, 2'b00, 20'h08001, 20'h08001, 4'd0, 0, 4'b0001);
      wait_done(lat);
      checks++;
      if (result !== 20'h0 || {Zout, Vout, Nout, Cout} !== 4'b1100) begin
         errors++;
         $display("FAIL xor res_zvnc got %h %b exp 00000 1100",
                  result, {Zout, Vout, Nout, Cout}); end
      drive(0, 4'hE, 2'b00, 20'h00000, 20'h04000, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (result !== 20'h08000 || {Zout, Vout, Nout, Cout} !== 4'b0110) begin
         errors++;
         $display("FAIL rla res_zvnc got %h %b exp 08000 0110",
                  result, {Zout, Vout, Nout, Cout}); end
   endtask

   task automatic test_flush();
      int seen;
      drive(0, 4'h0, 2'b00, 20'h00ABC, 20'h00000, 4'd0, 0, 4'b0000);
      wait_done(lat);
      drive(0, 4'hE, 2'b00, 20'h00000, 20'h00001, 4'd15, 0, 4'b0000);
      repeat (2) @(negedge MCLK);
      flush = 1'b1;
      @(negedge MCLK);
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++;
         $display("FAIL flush in_ready got %b exp 1", in_ready); end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) seen++;
         @(negedge MCLK);
      end
      checks++;
      if (seen !== 0) begin errors++;
         $display("FAIL flush done_count got %0d exp 0", seen); end
      checks++;
      if (result !== 20'h00ABC || {Zout, Vout, Nout, Cout} !== 4'b0000) begin
         errors++;
         $display("FAIL flush hold got %h %b exp 00ABC 0000",
                  result, {Zout, Vout, Nout, Cout}); end
      @(negedge MCLK);
      flush = 1'b1;
      drive(1, 4'h1, 2'b00, 20'h00002, 20'h00003, 4'd0, 0, 4'b0000);
      flush = 1'b0;
      wait_done(lat);
      checks++;
      if (lat !== 2 || result !== 20'h00005) begin errors++;
         $display("FAIL flush_idle lat_res got %0d %h exp 2 00005",
                  lat, result); end
   endtask

   task automatic test_rst_mid();
      int seen;
      drive(0, 4'hE, 2'b00, 20'h00000, 20'h00001, 4'd15, 0, 4'b1111);
      repeat (2) @(negedge MCLK);
      RST_n = 1'b0;
      #1;
      checks++;
      if (result !== 20'h0 || {res_wr, Zout, Vout, Nout, Cout, err} !== 6'b0)
      begin errors++;
         $display("FAIL rst_mid outs got %h %b exp 00000 000000", result,
                  {res_wr, Zout, Vout, Nout, Cout, err}); end
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin errors++;
         $display("FAIL rst_mid rdy_done got %b%b exp 10", in_ready, done);
      end
      @(negedge MCLK);
      RST_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge MCLK);
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++;
         $display("FAIL rst_mid done_count got %0d exp 0", seen); end
   endtask

   task automatic test_back_to_back();
      drive(0, 4'h1, 2'b00, 20'h00001, 20'h00001, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b1 || result !== 20'h00002) begin
         errors++;
         $display("FAIL b2b first got d=%b r=%b %h exp 1 1 00002",
                  done, in_ready, result); end
      drive(1, 4'h2, 2'b00, 20'h00001, 20'h00000, 4'd2, 0, 4'b0001);
      wait_done(lat);
      checks++;
      if (lat !== 4) begin errors++;
         $display("FAIL b2b latency got %0d exp 4", lat); end
      checks++;
      if (result !== 20'h00004 || {Zout, Vout, Nout, Cout} !== 4'b0000) begin
         errors++;
         $display("FAIL b2b res_zvnc got %h %b exp 00004 0000",
                  result, {Zout, Vout, Nout, Cout}); end
   endtask

   task automatic test_illegal();
`ifdef FU_ILLEGAL_TRAP_EN
      drive(0, 4'hF, 2'b00, 20'h00055, 20'h00000, 4'd3, 0, 4'b1111);
      wait_done(lat);
      checks++;
      if (lat !== 2 || err !== 1'b1 || result !== 20'h0DEAD) begin errors++;
         $display("FAIL trap lat_err_res got %0d %b %h exp 2 1 0DEAD",
                  lat, err, result); end
      checks++;
      if (res_wr !== 1'b0 || {Zout, Vout, Nout, Cout} !== 4'b0000) begin
         errors++;
         $display("FAIL trap wr_zvnc got %b %b exp 0 0000",
                  res_wr, {Zout, Vout, Nout, Cout}); end
`else
      drive(0, 4'hF, 2'b11, 20'h12355, 20'h00000, 4'd0, 0, 4'b0000);
      wait_done(lat);
      checks++;
      if (lat !== 2 || err !== 1'b0 || result !== 20'h02355) begin errors++;
         $display("FAIL rsv_mov lat_err_res got %0d %b %h exp 2 0 02355",
                  lat, err, result); end
      checks++;
      if (res_wr !== 1'b1) begin errors++;
         $display("FAIL rsv_mov res_wr got %b exp 1", res_wr); end
`endif
   endtask

   initial begin
      test_reset();
      test_add_word();
      test_rrc_addr();
      test_width_dadd();
      test_cmp_misc();
      test_flush();
      test_back_to_back();
      test_illegal();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
